// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// adder_share_arbiter: round-robin time-sharing of one external 32-bit adder
// among N_REQ requesters, with a one-entry registered response buffer.
// Revision: 1.0
// ============================================================================
module adder_share_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [32*N_REQ-1:0]  req_a_i,
  input  logic [32*N_REQ-1:0]  req_b_i,
  input  logic [N_REQ-1:0]     req_cin_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [31:0]          add_a_o,
  output logic [31:0]          add_b_o,
  output logic                 add_cin_o,
  input  logic [31:0]          add_sum_i,
  input  logic                 add_cout_i,
  output logic                 rsp_valid_o,
  output logic [1:0]           rsp_id_o,
  output logic [31:0]          rsp_sum_o,
  output logic                 rsp_cout_o,
  output logic                 rsp_ovf_o,
  input  logic                 rsp_ready_i
);

  localparam logic [2:0] c_N_REQ = 3'(N_REQ);

  logic [1:0]  rr_ptr_q,    rr_ptr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_id_q,    rsp_id_d;
  logic [31:0] rsp_sum_q,   rsp_sum_d;
  logic        rsp_cout_q,  rsp_cout_d;
  logic        rsp_ovf_q,   rsp_ovf_d;

  logic        w_can_accept;
  logic [3:0]  w_valid_ext;
  logic [2:0]  w_cand;
  logic        w_gnt_vld;
  logic [1:0]  w_gnt_idx;
  logic        w_ovf;

  assign w_can_accept = !rsp_valid_q || rsp_ready_i;
  assign w_valid_ext  = 4'(req_valid_i);

  // Scan from rr_ptr upward, wrapping at N_REQ; the first valid requester wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = 2'd0;
    w_cand    = 3'd0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = 3'(rr_ptr_q) + 3'(k);
      if (w_cand >= c_N_REQ) begin
        w_cand = w_cand - c_N_REQ;
      end
      if (!w_gnt_vld && !rst && w_can_accept && w_valid_ext[w_cand[1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand[1:0];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    add_a_o     = 32'd0;
    add_b_o     = 32'd0;
    add_cin_o   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_vld && (w_gnt_idx == 2'(i))) begin
        req_ready_o[i] = 1'b1;
        add_a_o        = req_a_i[32*i +: 32];
        add_b_o        = req_b_i[32*i +: 32];
        add_cin_o      = req_cin_i[i];
      end
    end
  end

  assign w_ovf = (add_a_o[31] == add_b_o[31]) && (add_sum_i[31] != add_a_o[31]);

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_ovf_d   = rsp_ovf_q;
    if (w_gnt_vld) begin
      // A grant only happens when the buffer is empty or draining, so the
      // new result may overwrite in place without a bubble.
      rsp_valid_d = 1'b1;
      rsp_id_d    = w_gnt_idx;
      rsp_sum_d   = add_sum_i;
      rsp_cout_d  = add_cout_i;
      rsp_ovf_d   = w_ovf;
      rr_ptr_d    = (3'(w_gnt_idx) == c_N_REQ - 3'd1) ? 2'd0 : w_gnt_idx + 2'd1;
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 2'd0;
      rsp_sum_q   <= 32'd0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_sum_o   = rsp_sum_q;
  assign rsp_cout_o  = rsp_cout_q;
  assign rsp_ovf_o   = rsp_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_adder_share_arbiter: directed plus random stimulus against a reference model.
// Revision: 1.0
// ============================================================================
module tb_adder_share_arbiter;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_cin, req_ready;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]   add_a, add_b, add_sum;
  logic          add_cin, add_cout;
  logic          rsp_valid, rsp_cout, rsp_ovf, rsp_ready;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_sum;

  int n_cmp = 0;
  int n_err = 0;

  // reference state
  logic        m_valid, m_cout, m_ovf;
  int          m_id, m_ptr;
  logic [31:0] m_sum;

  always #5 clk = ~clk;

  // the shared adder lives outside the DUT
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  adder_share_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_cin_i(req_cin),
    .req_ready_o(req_ready),
    .add_a_o(add_a), .add_b_o(add_b), .add_cin_o(add_cin),
    .add_sum_i(add_sum), .add_cout_i(add_cout),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_sum_o(rsp_sum),
    .rsp_cout_o(rsp_cout), .rsp_ovf_o(rsp_ovf), .rsp_ready_i(rsp_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (rst || !(!m_valid || rsp_ready)) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // Inputs are already driven (just after a negedge); check, clock, update model.
  task automatic cycle();
    int g;
    logic [32:0] s;
    longint sa;
    logic [31:0] a, b;
    #1;
    g = model_grant();
    check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    check("rsp_id",    64'(rsp_id),    64'(m_id));
    check("rsp_sum",   64'(rsp_sum),   64'(m_sum));
    check("rsp_cout",  64'(rsp_cout),  64'(m_cout));
    check("rsp_ovf",   64'(rsp_ovf),   64'(m_ovf));
    if (g < 0) begin
      check("req_ready", 64'(req_ready), 64'd0);
      check("add_a",     64'(add_a),     64'd0);
      check("add_b",     64'(add_b),     64'd0);
      check("add_cin",   64'(add_cin),   64'd0);
    end else begin
      check("req_ready", 64'(req_ready), 64'(1) << g);
      check("add_a",     64'(add_a),     64'(req_a[32*g +: 32]));
      check("add_b",     64'(add_b),     64'(req_b[32*g +: 32]));
      check("add_cin",   64'(add_cin),   64'(req_cin[g]));
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_id = 0; m_sum = 0; m_cout = 0; m_ovf = 0; m_ptr = 0;
    end else if (g >= 0) begin
      a = req_a[32*g +: 32];
      b = req_b[32*g +: 32];
      s = 33'(a) + 33'(b) + 33'(req_cin[g]);
      sa = longint'($signed(a)) + longint'($signed(b)) + longint'(req_cin[g]);
      m_valid = 1; m_id = g; m_sum = s[31:0]; m_cout = s[32];
      m_ovf = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
      m_ptr = (g + 1) % N;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
    req_valid[i] = v;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_cin[i] = c;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1; rsp_ready = 0;
    req_valid = '0; req_cin = '0; req_a = '0; req_b = '0;
    @(posedge clk);
    @(negedge clk);
    m_valid = 0; m_id = 0; m_sum = 0; m_cout = 0; m_ovf = 0; m_ptr = 0;
    cycle();                      // reset state with rst still high
    rst = 0;
    cycle();

    // single request
    rsp_ready = 1;
    set_req(1, 1, 32'h5, 32'h3, 1);
    #1 check("single_ready", 64'(req_ready), 64'b010);
    cycle();
    set_req(1, 0, 0, 0, 0);
    check("single_sum", 64'(rsp_sum), 64'h9);
    check("single_id",  64'(rsp_id),  64'd1);
    cycle();

    // carry and overflow
    set_req(0, 1, 32'hFFFF_FFFF, 32'h1, 0);
    cycle();
    check("carry_sum",  64'(rsp_sum),  64'd0);
    check("carry_cout", 64'(rsp_cout), 64'd1);
    check("carry_ovf",  64'(rsp_ovf),  64'd0);
    set_req(0, 1, 32'h7FFF_FFFF, 32'h1, 0);
    cycle();
    check("ovf_sum",  64'(rsp_sum),  64'h8000_0000);
    check("ovf_cout", 64'(rsp_cout), 64'd0);
    check("ovf_flag", 64'(rsp_ovf),  64'd1);
    set_req(0, 0, 0, 0, 0);

    // round-robin from a fresh pointer
    rst = 1; cycle(); rst = 0;
    for (int i = 0; i < N; i++) set_req(i, 1, 32'(100 * (i + 1)), 32'(i), 0);
    for (int k = 0; k < 6; k++) begin
      #1 check("rr_grant", 64'(req_ready), 64'(1) << (k % N));
      cycle();
      check("rr_rsp_id", 64'(rsp_id), 64'(k % N));
      check("rr_rsp_valid", 64'(rsp_valid), 64'd1);
    end
    for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, 0);

    // backpressure: buffer full, req 2 waiting
    rsp_ready = 0;
    set_req(2, 1, 32'hDEAD_0000, 32'h0000_BEEF, 1);
    for (int k = 0; k < 4; k++) begin
      #1 check("bp_ready", 64'(req_ready), 64'd0);
      cycle();
    end
    rsp_ready = 1;
    #1 check("bp_release", 64'(req_ready), 64'b100);
    cycle();
    check("bp_rsp_id", 64'(rsp_id), 64'd2);
    set_req(2, 0, 0, 0, 0);

    // reset mid-operation
    for (int i = 0; i < N; i++) set_req(i, 1, $urandom, $urandom, 1'($urandom));
    rsp_ready = 0;
    cycle();
    rst = 1;
    cycle();
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_sum",   64'(rsp_sum),   64'd0);
    rst = 0;
    set_req(0, 1, 32'h1, 32'h2, 0);
    #1 check("rst_first_grant", 64'(req_ready), 64'b111 & 64'b001);
    cycle();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 60) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)), rnd_op(), rnd_op(), 1'($urandom));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter that time-shares one 32-bit ripple-of-CLA adder (adder_32_bit) between up to N_REQ requesters (PC increment, branch-target and ALU add paths in KGPminiRISC). Each cycle it grants at most one valid request and steers that request's operands onto the shared adder. It registers the sum, carry-out, signed overflow and requester ID into a one-entry response buffer with a valid/ready handshake. The adder is instantiated outside this block and connected through the add_* ports.

## Interface
- N_REQ, 3, number of requesters (2..4); ID width is 2 bits.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  request i is presenting operands.
- req_a  in  32*N_REQ  operand A, requester i in bits [32i+31:32i].
- req_b  in  32*N_REQ  operand B, same packing.
- req_cin  in  N_REQ  carry-in per requester.
- req_ready  out  N_REQ  one-hot (or zero) grant; request i is accepted in a cycle where req_valid[i] and req_ready[i] are both 1.
- add_a  out  32  to shared adder a.
- add_b  out  32  to shared adder b.
- add_cin  out  1  to shared adder c_in.
- add_sum  in  32  from shared adder sum.
- add_cout  in  1  from shared adder c_out.
- rsp_valid  out  1  response buffer holds a result.
- rsp_id  out  2  index of the requester that owns the result.
- rsp_sum  out  32  registered sum.
- rsp_cout  out  1  registered carry-out.
- rsp_ovf  out  1  registered signed overflow.
- rsp_ready  in  1  consumer takes the response when rsp_valid and rsp_ready are both 1.

## Operation
- State: rr_ptr (2 bits, next-highest-priority index), response buffer (rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf).
- can_accept = !rsp_valid | rsp_ready (buffer empty or draining this cycle).
- Grant: when can_accept, search req_valid starting at rr_ptr, wrapping modulo N_REQ. The first set bit is granted and its req_ready bit is set. Otherwise req_ready = 0.
- req_ready depends combinationally on req_valid, rr_ptr, rsp_valid and rsp_ready. Requesters must not derive req_valid from req_ready.
- Adder steering: add_a, add_b and add_cin carry the granted requester's operands. With no grant they are all 0.
- On accept of request g: rsp_valid <= 1, rsp_id <= g, rsp_sum <= add_sum, rsp_cout <= add_cout.
  - rsp_ovf <= (add_a[31] == add_b[31]) & (add_sum[31] != add_a[31]).
  - rr_ptr <= (g+1) mod N_REQ.
- No accept but rsp_valid & rsp_ready: rsp_valid <= 0. Data fields keep their old values.
- No accept and not draining: everything holds. While rsp_valid=1 and rsp_ready=0, all rsp_* outputs are stable.
- Simultaneous drain and accept: the new result replaces the old one in the same edge, with no bubble. Full throughput is one add per cycle.
- rr_ptr advances only on a grant. Idle cycles leave it unchanged.
- Requesters with index >= N_REQ do not exist; rr_ptr never takes values >= N_REQ.

## Timing
- Reset (rst=1 at edge): rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, rr_ptr=0.
- While rst=1, req_ready=0 and add_a/add_b/add_cin=0.
- Reset overrides any handshake in the same cycle, and an in-flight result is discarded.
- Latency: a request accepted in cycle t appears on rsp_* with rsp_valid=1 in cycle t+1.
- The adder path is combinational within the accept cycle. The register-to-register path is req mux, then adder_32_bit, then the response register.
- Fairness: a continuously asserted request waits at most N_REQ-1 grants to other requesters, provided the consumer keeps draining.

## Test plan
- Reset, then a single request.
  - Stimulus: after reset, req 1 presents a=0x0000_0005, b=0x0000_0003, cin=1.
  - Response: req_ready=3'b010 the same cycle; the next cycle rsp_valid=1, rsp_id=1, rsp_sum=0x0000_0009, cout=0, ovf=0.
- Carry and overflow.
  - Stimulus 1: a=0xFFFF_FFFF, b=0x0000_0001, cin=0. Response: sum=0, cout=1, ovf=0.
  - Stimulus 2: a=0x7FFF_FFFF, b=0x0000_0001. Response: sum=0x8000_0000, cout=0, ovf=1.
- Round-robin.
  - Stimulus: all 3 requests held valid, rsp_ready=1 for 6 cycles.
  - Response: grants in order 0,1,2,0,1,2 and rsp_id follows one cycle later. One result per cycle with no gaps.
- Backpressure.
  - Stimulus: rsp_ready=0 with a result buffered, while req 2 is valid.
  - Response: req_ready=0 and rsp_* stable for every held cycle. The cycle rsp_ready rises, req 2 is granted, and the next cycle shows req 2's result.
- Reset mid-operation.
  - Stimulus: assert rst while rsp_valid=1 and requests are pending.
  - Response: the next cycle rsp_valid=0 and all rsp_* fields are 0. After release, the first grant goes to req 0 (rr_ptr=0).
